iq_demod: RTL

Quadrature accumulate-and-dump demodulator that consumes the `cos`/`sin` outputs of the sinusoidal oscillator stage as its local oscillator (LO). It mixes a signed input sample stream against the LO and integrates 2**LOG2_DECIM products per channel. It then emits one averaged I/Q pair through a valid/ready output holding register. It sits directly downstream of the oscillator, between the sample source and any I/Q consumer such as a magnitude/phase estimator.

---
 rtl/iq_demod.sv | 116 +++++++++++
 1 files changed

// File: rtl/iq_demod.sv
// Quadrature accumulate-and-dump demodulator: mixes samples against the LO, integrates 2**LOG2_DECIM products.
// Define IQ_DEMOD_ROUND_EN for round-half-up scaling; default build truncates toward -inf.
module iq_demod #(
    parameter int WIDTH      = 8,
    parameter int LOG2_DECIM = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    input  logic signed [WIDTH-1:0]     in_data,
    input  logic signed [WIDTH-1:0]     cos,
    input  logic signed [WIDTH-1:0]     sin,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic signed [2*WIDTH-1:0]   out_i,
    output logic signed [2*WIDTH-1:0]   out_q,
    output logic                        overrun
);

    localparam int ACC_W = 2*WIDTH + LOG2_DECIM;
    localparam int OUT_W = 2*WIDTH;
    localparam int DECIM = 1 << LOG2_DECIM;
    localparam int CNT_W = (LOG2_DECIM > 0) ? LOG2_DECIM : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DECIM - 1);
`ifdef IQ_DEMOD_ROUND_EN
    localparam logic signed [ACC_W-1:0] RND = ACC_W'(DECIM / 2);
`else
    localparam logic signed [ACC_W-1:0] RND = '0;
`endif

    typedef enum logic {EMPTY, FULL} state_t;

    logic [CNT_W-1:0]          cnt;
    logic signed [OUT_W-1:0]   p_i, p_q;
    logic                      p_valid, p_last;
    logic signed [ACC_W-1:0]   acc_i, acc_q;
    logic signed [ACC_W-1:0]   d_i, d_q;
    logic                      dump, load, drop;
    state_t                    state, state_nx;

    // Stage 1: full-precision products and end-of-block marker.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            p_i     <= '0;
            p_q     <= '0;
            p_valid <= 1'b0;
            p_last  <= 1'b0;
        end else begin
            p_valid <= in_valid;
            p_last  <= in_valid && (cnt == LAST);
            if (in_valid) begin
                p_i <= OUT_W'(in_data) * OUT_W'(cos);
                p_q <= OUT_W'(in_data) * OUT_W'(sin);
                cnt <= (cnt == LAST) ? '0 : cnt + CNT_W'(1);
            end
        end
    end

    // Stage 2: the dump value includes the final product without waiting for it to land in acc.
    assign d_i  = acc_i + ACC_W'(p_i);
    assign d_q  = acc_q + ACC_W'(p_q);
    assign dump = p_valid && p_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_i <= '0;
            acc_q <= '0;
        end else if (p_valid) begin
            acc_i <= p_last ? '0 : d_i;
            acc_q <= p_last ? '0 : d_q;
        end
    end

    // Output holding register FSM.
    always_ff @(posedge clk) begin
        if (rst) state <= EMPTY;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            EMPTY: if (dump) state_nx = FULL;
            FULL:  if (out_ready && !dump) state_nx = EMPTY;
            default: state_nx = EMPTY;
        endcase
    end

    // NOTE: every output of this block gets a default first, so no latch is inferred.
    always_comb begin
        load      = 1'b0;
        drop      = 1'b0;
        out_valid = (state == FULL);
        if (dump) begin
            if (state == EMPTY || out_ready) load = 1'b1;
            else                             drop = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_i   <= '0;
            out_q   <= '0;
            overrun <= 1'b0;
        end else begin
            if (load) begin
                out_i <= OUT_W'((d_i + RND) >>> LOG2_DECIM);
                out_q <= OUT_W'((d_q + RND) >>> LOG2_DECIM);
            end
            if (drop) overrun <= 1'b1;
        end
    end

endmodule
